// File: rtl/stream_prefetcher_pkg.sv
// stream_prefetcher_pkg
// Shared definitions for the next-line prefetch controller: default geometry,
// the line/label types for that geometry and the controller state encoding.
package stream_prefetcher_pkg;

  localparam int LINE_WIDTH_DEF  = 256;
  localparam int PAGE_BYTES_DEF  = 4096;
  localparam int LABEL_WIDTH_DEF = 32 - $clog2(LINE_WIDTH_DEF / 8);

  typedef logic [LABEL_WIDTH_DEF-1:0] label_t;
  typedef logic [LINE_WIDTH_DEF-1:0]  line_t;

  typedef enum logic [1:0] {
    IDLE,
    DEMAND_WAIT,
    PF_ISSUE,
    DRAIN
  } pf_state_t;

endpackage

// File: rtl/pf_stats.sv
// pf_stats
// Pair of 32-bit saturating event counters for the prefetch controller.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   hit_inc            one-cycle pulse: resident hit or hit-under-prefetch
//   miss_inc           one-cycle pulse: demand strobe issued
//   hit_cnt, miss_cnt  counter values, stick at all-ones
module pf_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        hit_inc,
  input  logic        miss_inc,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_inc)  hit_cnt  <= sat_inc(hit_cnt);
      if (miss_inc) miss_cnt <= sat_inc(miss_cnt);
    end
  end

endmodule

// File: rtl/stream_prefetcher.sv
// stream_prefetcher
// Next-line prefetch controller in front of stream_buffer. Demand misses
// become buffer requests; once a line is returned to the cache the next
// sequential line (within the same page) is requested so streaming code hits.
// At most one buffer fetch is outstanding at any time.
// Optional build macro: STREAM_PREFETCHER_STATS_EN adds hit_cnt / miss_cnt.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   miss_req        cache miss, held until resp_vld
//   miss_label      missed line label
//   resp_vld        one-cycle pulse, resp_data holds the requested line
//   resp_data       returned line (registered)
//   sb_label_i      label requested from stream_buffer
//   sb_label_i_rdy  one-cycle request strobe to stream_buffer
//   sb_label_o      label of line resident in stream_buffer
//   sb_data         resident line data
//   sb_data_vld     resident line valid
//   hit_cnt         (macro only) resident hits + hits-under-prefetch
//   miss_cnt        (macro only) demand strobes issued
module stream_prefetcher
  import stream_prefetcher_pkg::*;
#(
  parameter int  LINE_WIDTH  = LINE_WIDTH_DEF,
  parameter int  PAGE_BYTES  = PAGE_BYTES_DEF,
  localparam int LABEL_WIDTH = 32 - $clog2(LINE_WIDTH / 8),
  localparam int PAGE_LINES  = PAGE_BYTES / (LINE_WIDTH / 8)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   miss_req,
  input  logic [LABEL_WIDTH-1:0] miss_label,
  output logic                   resp_vld,
  output logic [LINE_WIDTH-1:0]  resp_data,
  output logic [LABEL_WIDTH-1:0] sb_label_i,
  output logic                   sb_label_i_rdy,
  input  logic [LABEL_WIDTH-1:0] sb_label_o,
  input  logic [LINE_WIDTH-1:0]  sb_data,
  input  logic                   sb_data_vld
`ifdef STREAM_PREFETCHER_STATS_EN
  ,
  output logic [31:0]            hit_cnt,
  output logic [31:0]            miss_cnt
`endif
);

  localparam int PAGE_BITS = $clog2(PAGE_LINES);

  pf_state_t              state, state_nxt;
  logic                   busy, busy_nxt;
  logic [LABEL_WIDTH-1:0] out_label, out_label_nxt;
  // Label of the request being served; miss_label is only guaranteed stable
  // while miss_req is high, and PF_ISSUE runs after the response.
  logic [LABEL_WIDTH-1:0] cur_label, cur_label_nxt;
  logic                   resp_vld_nxt;
  logic [LINE_WIDTH-1:0]  resp_data_nxt;
  logic [LABEL_WIDTH-1:0] sb_label_nxt;
  logic                   rdy_nxt;
  logic                   hit_inc, miss_inc;
  logic                   resident_hit;

  assign resident_hit = sb_data_vld && !busy && (sb_label_o == miss_label);

  always_comb begin
    state_nxt     = state;
    busy_nxt      = busy;
    out_label_nxt = out_label;
    cur_label_nxt = cur_label;
    resp_vld_nxt  = 1'b0;
    resp_data_nxt = resp_data;
    sb_label_nxt  = sb_label_i;
    rdy_nxt       = 1'b0;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    case (state)
      IDLE: begin
        // A prefetch landing while idle ends the outstanding fetch.
        if (busy && sb_data_vld && (sb_label_o == out_label)) busy_nxt = 1'b0;
        if (miss_req) begin
          cur_label_nxt = miss_label;
          if (resident_hit) begin
            resp_data_nxt = sb_data;
            resp_vld_nxt  = 1'b1;
            hit_inc       = 1'b1;
            state_nxt     = PF_ISSUE;
          end else if (!busy) begin
            rdy_nxt       = 1'b1;
            sb_label_nxt  = miss_label;
            busy_nxt      = 1'b1;
            out_label_nxt = miss_label;
            miss_inc      = 1'b1;
            state_nxt     = DEMAND_WAIT;
          end else if (miss_label == out_label) begin
            // The wanted line is already on its way: just wait for it.
            hit_inc   = 1'b1;
            state_nxt = DEMAND_WAIT;
          end else begin
            // In-flight fetch cannot be cancelled; let it finish first.
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (sb_data_vld && (sb_label_o == out_label)) begin
          rdy_nxt       = 1'b1;
          sb_label_nxt  = cur_label;
          busy_nxt      = 1'b1;
          out_label_nxt = cur_label;
          miss_inc      = 1'b1;
          state_nxt     = DEMAND_WAIT;
        end
      end
      DEMAND_WAIT: begin
        if (sb_data_vld && (sb_label_o == cur_label)) begin
          busy_nxt      = 1'b0;
          resp_data_nxt = sb_data;
          resp_vld_nxt  = 1'b1;
          state_nxt     = PF_ISSUE;
        end
      end
      PF_ISSUE: begin
        // Last line of a page (includes the all-ones label) gets no prefetch,
        // so the label never wraps and the page is never crossed.
        if (!(&cur_label[PAGE_BITS-1:0])) begin
          rdy_nxt       = 1'b1;
          sb_label_nxt  = cur_label + 1'b1;
          busy_nxt      = 1'b1;
          out_label_nxt = cur_label + 1'b1;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      out_label      <= '0;
      cur_label      <= '0;
      resp_vld       <= 1'b0;
      resp_data      <= '0;
      sb_label_i     <= '0;
      sb_label_i_rdy <= 1'b0;
    end else begin
      state          <= state_nxt;
      busy           <= busy_nxt;
      out_label      <= out_label_nxt;
      cur_label      <= cur_label_nxt;
      resp_vld       <= resp_vld_nxt;
      resp_data      <= resp_data_nxt;
      sb_label_i     <= sb_label_nxt;
      sb_label_i_rdy <= rdy_nxt;
    end
  end

`ifdef STREAM_PREFETCHER_STATS_EN
  pf_stats u_stats (
    .clk      (clk),
    .rst      (rst),
    .hit_inc  (hit_inc),
    .miss_inc (miss_inc),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );
`else
  logic unused_stats;
  assign unused_stats = hit_inc ^ miss_inc;
`endif

endmodule

// File: tb/tb_stream_prefetcher.sv
// tb_stream_prefetcher
// Directed bench for stream_prefetcher: the bench plays both the cache and
// the stream_buffer, driving the buffer's resident label/data/valid by hand.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_stream_prefetcher;
  import stream_prefetcher_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_req;
  logic [26:0]  miss_label;
  logic         resp_vld;
  logic [255:0] resp_data;
  logic [26:0]  sb_label_i;
  logic         sb_label_i_rdy;
  logic [26:0]  sb_label_o;
  logic [255:0] sb_data;
  logic         sb_data_vld;
`ifdef STREAM_PREFETCHER_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  stream_prefetcher dut (
    .clk            (clk),
    .rst            (rst),
    .miss_req       (miss_req),
    .miss_label     (miss_label),
    .resp_vld       (resp_vld),
    .resp_data      (resp_data),
    .sb_label_i     (sb_label_i),
    .sb_label_i_rdy (sb_label_i_rdy),
    .sb_label_o     (sb_label_o),
    .sb_data        (sb_data),
    .sb_data_vld    (sb_data_vld)
`ifdef STREAM_PREFETCHER_STATS_EN
    ,
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] line_of(input logic [26:0] l);
    return {8{5'd0, l}} ^ {32'hC0DE_0000, 224'd0};
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic buf_set(input logic [26:0] l, input logic v);
    sb_label_o  = l;
    sb_data     = line_of(l);
    sb_data_vld = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; miss_req = 1'b0; miss_label = '0;
    sb_label_o = '0; sb_data = '0; sb_data_vld = 1'b0;
    tick(); tick();
    chk("rst_resp_vld", 256'(resp_vld), 256'h0);
    chk("rst_resp_data", resp_data, 256'h0);
    chk("rst_sb_label_i", 256'(sb_label_i), 256'h0);
    chk("rst_rdy", 256'(sb_label_i_rdy), 256'h0);
    rst = 1'b1;
    tick();

    // Cold miss 0x100
    miss_req = 1'b1; miss_label = 27'h100;
    tick();
    chk("cold_rdy", 256'(sb_label_i_rdy), 256'h1);
    chk("cold_label", 256'(sb_label_i), 256'h100);
    chk("cold_no_resp", 256'(resp_vld), 256'h0);
    tick();
    chk("cold_rdy_pulse", 256'(sb_label_i_rdy), 256'h0);
    buf_set(27'h100, 1'b1);
    tick();
    chk("cold_resp_vld", 256'(resp_vld), 256'h1);
    chk("cold_resp_data", resp_data, line_of(27'h100));
    miss_req = 1'b0;
    tick();
    chk("cold_pf_rdy", 256'(sb_label_i_rdy), 256'h1);
    chk("cold_pf_label", 256'(sb_label_i), 256'h101);
    chk("cold_resp_pulse", 256'(resp_vld), 256'h0);
    sb_data_vld = 1'b0;
    tick();
    buf_set(27'h101, 1'b1);
    tick();

    // Resident hit 0x101
    miss_req = 1'b1; miss_label = 27'h101;
    tick();
    chk("hit_resp_vld", 256'(resp_vld), 256'h1);
    chk("hit_resp_data", resp_data, line_of(27'h101));
    chk("hit_no_strobe", 256'(sb_label_i_rdy), 256'h0);
    miss_req = 1'b0;
    tick();
    chk("hit_pf_rdy", 256'(sb_label_i_rdy), 256'h1);
    chk("hit_pf_label", 256'(sb_label_i), 256'h102);
    sb_data_vld = 1'b0;

    // Hit-under-prefetch 0x102
    miss_req = 1'b1; miss_label = 27'h102;
    tick();
    chk("hup_no_strobe", 256'(sb_label_i_rdy), 256'h0);
    tick();
    chk("hup_wait_resp", 256'(resp_vld), 256'h0);
    buf_set(27'h102, 1'b1);
    tick();
    chk("hup_resp_vld", 256'(resp_vld), 256'h1);
    chk("hup_resp_data", resp_data, line_of(27'h102));
    miss_req = 1'b0;
    tick();
    chk("hup_pf_label", 256'(sb_label_i), 256'h103);
    chk("hup_pf_rdy", 256'(sb_label_i_rdy), 256'h1);
    sb_data_vld = 1'b0;

    // Miss 0x200 while 0x103 in flight: drain then demand
    miss_req = 1'b1; miss_label = 27'h200;
    tick();
    chk("drain_no_strobe0", 256'(sb_label_i_rdy), 256'h0);
    tick();
    chk("drain_no_strobe1", 256'(sb_label_i_rdy), 256'h0);
    buf_set(27'h103, 1'b1);
    tick();
    chk("drain_rdy", 256'(sb_label_i_rdy), 256'h1);
    chk("drain_label", 256'(sb_label_i), 256'h200);
    chk("drain_no_resp", 256'(resp_vld), 256'h0);
    sb_data_vld = 1'b0;
    tick();
    buf_set(27'h200, 1'b1);
    tick();
    chk("drain_resp_vld", 256'(resp_vld), 256'h1);
    chk("drain_resp_data", resp_data, line_of(27'h200));
    miss_req = 1'b0;
    tick();
    chk("drain_pf_label", 256'(sb_label_i), 256'h201);
    sb_data_vld = 1'b0;
    tick();
    buf_set(27'h201, 1'b1);
    tick();

    // Page end 0x17F: no prefetch
    miss_req = 1'b1; miss_label = 27'h17F;
    tick();
    chk("pg_rdy", 256'(sb_label_i_rdy), 256'h1);
    chk("pg_label", 256'(sb_label_i), 256'h17F);
    buf_set(27'h17F, 1'b1);
    tick();
    chk("pg_resp_vld", 256'(resp_vld), 256'h1);
    chk("pg_resp_data", resp_data, line_of(27'h17F));
    miss_req = 1'b0;
    tick();
    chk("pg_no_pf", 256'(sb_label_i_rdy), 256'h0);
    tick();
    chk("pg_no_pf_late", 256'(sb_label_i_rdy), 256'h0);

    // All-ones label: no wrap to 0
    miss_req = 1'b1; miss_label = 27'h7FFFFFF;
    tick();
    chk("wrap_rdy", 256'(sb_label_i_rdy), 256'h1);
    chk("wrap_label", 256'(sb_label_i), 256'h7FFFFFF);
    buf_set(27'h7FFFFFF, 1'b1);
    tick();
    chk("wrap_resp_data", resp_data, line_of(27'h7FFFFFF));
    miss_req = 1'b0;
    tick();
    chk("wrap_no_pf", 256'(sb_label_i_rdy), 256'h0);
    chk("wrap_label_kept", 256'(sb_label_i), 256'h7FFFFFF);
`ifdef STREAM_PREFETCHER_STATS_EN
    chk("stat_hit", 256'(hit_cnt), 256'd2);
    chk("stat_miss", 256'(miss_cnt), 256'd4);
`endif
    tick();

    // Reset during DEMAND_WAIT
    miss_req = 1'b1; miss_label = 27'h300;
    tick();
    chk("rw_rdy", 256'(sb_label_i_rdy), 256'h1);
    tick();
    rst = 1'b0;
    #2;
    chk("rw_resp_vld", 256'(resp_vld), 256'h0);
    chk("rw_resp_data", resp_data, 256'h0);
    chk("rw_rdy0", 256'(sb_label_i_rdy), 256'h0);
    chk("rw_label0", 256'(sb_label_i), 256'h0);
    chk("rw_state", 256'(dut.state), 256'(IDLE));
`ifdef STREAM_PREFETCHER_STATS_EN
    chk("rw_hit_cnt", 256'(hit_cnt), 256'd0);
    chk("rw_miss_cnt", 256'(miss_cnt), 256'd0);
`endif
    miss_req = 1'b0;
    buf_set(27'h0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    miss_req = 1'b1; miss_label = 27'h300;
    tick();
    chk("rc_rdy", 256'(sb_label_i_rdy), 256'h1);
    chk("rc_label", 256'(sb_label_i), 256'h300);
    buf_set(27'h300, 1'b1);
    tick();
    chk("rc_resp_vld", 256'(resp_vld), 256'h1);
    chk("rc_resp_data", resp_data, line_of(27'h300));
    miss_req = 1'b0;
    tick();
    chk("rc_pf_label", 256'(sb_label_i), 256'h301);
`ifdef STREAM_PREFETCHER_STATS_EN
    chk("rc_miss_cnt", 256'(miss_cnt), 256'd1);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
